pc_ir_unit: RTL and testbench
=============================

// Module: pc_ir_unit
// PURPOSE
//  Fetch/decode-side datapath slice between instruction memory and the multicycle FSM.
//  Holds the PC, the instruction register (IR), the memory data register (MDR) and the
//  ALUOut register. It consumes the FSM strobes (PCWrite, PCSource, IRWrite, IorD,
//  MemRead, MemWrite) and returns opcode/fields to the FSM and register file.
//  Also keeps retired-instruction and cycle counters for debug.
// PARAMETERS
//  INSTR_WIDTH  16  instruction/data word width; format [15:12]op [11:8]rd [7:4]rs [3:0]rt
//  ADDR_WIDTH   8   PC / memory address width
//  OPCODE_SIZE  4   opcode field width (IR[INSTR_WIDTH-1 -: OPCODE_SIZE])
//  RESET_PC     0   PC value after reset
//  CNT_WIDTH    16  debug counter width
// PORTS
//  clk          in   1            system clock, all state on rising edge
//  reboot       in   1            synchronous, active-high reset
//  PCWrite      in   1            load PC this cycle
//  PCSource     in   2            00 alu_result, 01 branch target, 10 jump target, 11 hold
//  IRWrite      in   1            capture mem_rdata into IR
//  IorD         in   1            0: mem_addr=PC, 1: mem_addr=ALUOut register
//  MemRead      in   1            FSM read strobe
//  MemWrite     in   1            FSM write strobe
//  alu_result   in   INSTR_WIDTH  combinational ALU output
//  mem_rdata    in   INSTR_WIDTH  async-read memory data, valid same cycle as mem_read
//  mem_addr     out  ADDR_WIDTH   memory address
//  mem_read     out  1            MemRead gated by reset
//  mem_write    out  1            MemWrite gated by reset
//  pc           out  ADDR_WIDTH   current PC
//  opcode       out  OPCODE_SIZE  IR opcode field to FSM
//  rd, rs, rt   out  4 each       IR register fields
//  imm_sext     out  INSTR_WIDTH  IR[7:0] sign-extended
//  mdr          out  INSTR_WIDTH  memory data register (MemtoReg source)
//  alu_out      out  INSTR_WIDTH  ALUOut register
//  instr_count  out  CNT_WIDTH    number of IR loads since reset
//  cycle_count  out  CNT_WIDTH    cycles since reset
//  ir_err       out  1            sticky: IRWrite asserted without MemRead
// BEHAVIOUR
//  Reset (reboot=1 at posedge): pc=RESET_PC; IR, mdr, alu_out, counters=0; ir_err=0.
//   While reboot=1, mem_read=mem_write=0 combinationally. Reset mid-instruction aborts it.
//  Reset opcode = 0 (IR=0), so the FSM decodes from a known IR.
//  PC update on posedge when PCWrite=1, selected by PCSource:
//   00: alu_result[ADDR_WIDTH-1:0]  (PC+1 during fetch)
//   01: pc + imm_sext[ADDR_WIDTH-1:0], modulo 2^ADDR_WIDTH (branch)
//   10: {pc[ADDR_WIDTH-1:ADDR_WIDTH-4]... no: IR[ADDR_WIDTH-1:0]} = IR low ADDR_WIDTH bits (jump)
//   11: pc unchanged. PCWrite=0: pc unchanged regardless of PCSource.
//   Branch/jump use pc value *before* this edge; PC arithmetic wraps, no overflow flag.
//  IR: loads mem_rdata at posedge iff IRWrite=1 and MemRead=1; instr_count += 1 (wraps).
//   IRWrite=1 with MemRead=0: IR holds, ir_err set (cleared only by reset).
//  Simultaneous IRWrite & PCWrite (fetch): IR gets mem_rdata at old PC, PC gets new value.
//  MDR: loads mem_rdata every cycle MemRead=1 and IorD=1 (data load); else holds.
//  ALUOut: loads alu_result every cycle (unconditional), 1-cycle latency.
//  mem_addr = IorD ? alu_out[ADDR_WIDTH-1:0] : pc (combinational).
//  MemRead & MemWrite both 1: mem_write forced 0, mem_read passes (read wins).
//  cycle_count += 1 every non-reset cycle, wraps at 2^CNT_WIDTH.
//  Field outputs are combinational slices of IR; no decode state of its own.
// TESTING
//  1 reboot 1 cycle, RESET_PC=0 -> pc=0, opcode=0, counters=0, mem_read=0 during reset.
//  2 fetch: MemRead=IRWrite=PCWrite=1, PCSource=00, mem_rdata=16'h1234, alu_result=1
//    -> next cycle IR=16'h1234, opcode=1, rd=2, rs=3, rt=4, pc=1, instr_count=1.
//  3 branch: pc=8'h05, IR[7:0]=8'hFE, PCWrite=1, PCSource=01 -> pc=8'h03;
//    pc=8'hFF, IR[7:0]=8'h02 -> pc=8'h01 (wrap).
//  4 jump: IR=16'hF0A7, PCSource=10, PCWrite=1 -> pc=8'hA7; PCSource=11 -> pc holds.
//  5 load: alu_result=16'h0040 one cycle, then IorD=1, MemRead=1, mem_rdata=16'hBEEF
//    -> mem_addr=8'h40, mdr=16'hBEEF next cycle; MemRead&MemWrite=1 -> mem_write=0.
//  6 IRWrite=1, MemRead=0 -> IR unchanged, ir_err=1 and stays 1; reboot mid-fetch -> all reset.

Source files
------------

// File: rtl/pc_ir_if.sv
// FSM-strobe and instruction-memory bus for the PC/IR slice.
// master drives strobes and memory data; slave returns address and strobes.
interface pc_ir_if #(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8
);
  logic                   PCWrite;
  logic [1:0]             PCSource;
  logic                   IRWrite;
  logic                   IorD;
  logic                   MemRead;
  logic                   MemWrite;
  logic [INSTR_WIDTH-1:0] alu_result;
  logic [INSTR_WIDTH-1:0] mem_rdata;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_read;
  logic                   mem_write;

  modport master (
    output PCWrite, PCSource, IRWrite, IorD,
    output MemRead, MemWrite, alu_result, mem_rdata,
    input  mem_addr, mem_read, mem_write
  );

  modport slave (
    input  PCWrite, PCSource, IRWrite, IorD,
    input  MemRead, MemWrite, alu_result, mem_rdata,
    output mem_addr, mem_read, mem_write
  );
endinterface

// File: rtl/pc_ir_unit.sv
// Multicycle fetch/decode slice: PC, IR, MDR, ALUOut and debug counters.
// Fields are combinational slices of IR; all state updates on rising clk.
module pc_ir_unit #(
  parameter int                  INSTR_WIDTH = 16,
  parameter int                  ADDR_WIDTH  = 8,
  parameter int                  OPCODE_SIZE = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reboot,
  pc_ir_if.slave                 bus,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic [OPCODE_SIZE-1:0] opcode,
  output logic [3:0]             rd,
  output logic [3:0]             rs,
  output logic [3:0]             rt,
  output logic [INSTR_WIDTH-1:0] imm_sext,
  output logic [INSTR_WIDTH-1:0] mdr,
  output logic [INSTR_WIDTH-1:0] alu_out,
  output logic [CNT_WIDTH-1:0]   instr_count,
  output logic [CNT_WIDTH-1:0]   cycle_count,
  output logic                   ir_err
);

  logic [INSTR_WIDTH-1:0] ir;
  logic [ADDR_WIDTH-1:0]  pc_nxt;
  logic                   ir_load;

  assign opcode   = ir[INSTR_WIDTH-1 -: OPCODE_SIZE];
  assign rd       = ir[11:8];
  assign rs       = ir[7:4];
  assign rt       = ir[3:0];
  assign imm_sext = {{(INSTR_WIDTH-8){ir[7]}}, ir[7:0]};

  assign ir_load  = bus.IRWrite & bus.MemRead;

  // Memory side: address mux and reset/read-priority strobe gating.
  always_comb begin
    bus.mem_addr  = bus.IorD ? alu_out[ADDR_WIDTH-1:0] : pc;
    bus.mem_read  = bus.MemRead & ~reboot;
    bus.mem_write = bus.MemWrite & ~bus.MemRead & ~reboot;
  end

  // Next-PC select; branch and jump use the PC/IR from before this edge.
  always_comb begin
    pc_nxt = pc;
    if (bus.PCWrite) begin
      unique case (bus.PCSource)
        2'b00:   pc_nxt = bus.alu_result[ADDR_WIDTH-1:0];
        2'b01:   pc_nxt = pc + imm_sext[ADDR_WIDTH-1:0];
        2'b10:   pc_nxt = ir[ADDR_WIDTH-1:0];
        default: pc_nxt = pc;
      endcase
    end
  end

  // Architectural registers and debug counters.
  always_ff @(posedge clk) begin
    if (reboot) begin
      pc          <= RESET_PC;
      ir          <= '0;
      mdr         <= '0;
      alu_out     <= '0;
      instr_count <= '0;
      cycle_count <= '0;
      ir_err      <= 1'b0;
    end else begin
      pc          <= pc_nxt;
      alu_out     <= bus.alu_result;
      cycle_count <= cycle_count + 1'b1;
      if (ir_load) begin
        ir          <= bus.mem_rdata;
        instr_count <= instr_count + 1'b1;
      end
      if (bus.IRWrite && !bus.MemRead)
        ir_err <= 1'b1;
      if (bus.MemRead && bus.IorD)
        mdr <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_pc_ir_unit.sv
// Bench for pc_ir_unit: directed scenarios then random strobes
// against an arithmetic reference model of the datapath slice.
module tb_pc_ir_unit;

  logic        clk = 1'b0;
  logic        reboot;
  logic [7:0]  pc;
  logic [3:0]  opcode, rd, rs, rt;
  logic [15:0] imm_sext, mdr, alu_out, instr_count, cycle_count;
  logic        ir_err;

  int total = 0;
  int bad   = 0;

  int m_pc, m_ir, m_mdr, m_alu, m_ic, m_cc, m_err;

  pc_ir_if #(.INSTR_WIDTH(16), .ADDR_WIDTH(8)) bus ();

  pc_ir_unit dut (
    .clk(clk), .reboot(reboot), .bus(bus),
    .pc(pc), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
    .imm_sext(imm_sext), .mdr(mdr), .alu_out(alu_out),
    .instr_count(instr_count), .cycle_count(cycle_count),
    .ir_err(ir_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit rb, input bit pw, input int psrc,
                       input bit irw, input bit iord, input bit mr,
                       input bit mw, input int alu, input int rdat);
    reboot         = rb;
    bus.PCWrite    = pw;
    bus.PCSource   = 2'(psrc);
    bus.IRWrite    = irw;
    bus.IorD       = iord;
    bus.MemRead    = mr;
    bus.MemWrite   = mw;
    bus.alu_result = 16'(alu);
    bus.mem_rdata  = 16'(rdat);
  endtask

  function automatic int sext8(input int v);
    int b;
    b = v & 'hFF;
    return (b >= 128) ? b - 256 : b;
  endfunction

  task automatic tick();
    int old_ir;
    @(posedge clk);
    if (reboot) begin
      m_pc = 0; m_ir = 0; m_mdr = 0; m_alu = 0;
      m_ic = 0; m_cc = 0; m_err = 0;
    end else begin
      old_ir = m_ir;
      if (bus.PCWrite) begin
        case (bus.PCSource)
          2'd0: m_pc = int'(bus.alu_result) & 'hFF;
          2'd1: m_pc = (m_pc + sext8(old_ir)) & 'hFF;
          2'd2: m_pc = old_ir & 'hFF;
          default: ;
        endcase
      end
      if (bus.IRWrite) begin
        if (bus.MemRead) begin
          m_ir = int'(bus.mem_rdata);
          m_ic = (m_ic + 1) & 'hFFFF;
        end else begin
          m_err = 1;
        end
      end
      if (bus.MemRead && bus.IorD) m_mdr = int'(bus.mem_rdata);
      m_alu = int'(bus.alu_result);
      m_cc  = (m_cc + 1) & 'hFFFF;
    end
    #1;
  endtask

  task automatic check_comb();
    int ea;
    ea = bus.IorD ? (m_alu & 'hFF) : m_pc;
    chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
    chk("mem_read", 32'(bus.mem_read), 32'(bus.MemRead && !reboot));
    chk("mem_write", 32'(bus.mem_write),
        32'(bus.MemWrite && !bus.MemRead && !reboot));
  endtask

  task automatic check_state();
    int es;
    es = sext8(m_ir) & 'hFFFF;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("ir", 32'({opcode, rd, rs, rt}), 32'(m_ir));
    chk("imm_sext", 32'(imm_sext), 32'(es));
    chk("mdr", 32'(mdr), 32'(m_mdr));
    chk("alu_out", 32'(alu_out), 32'(m_alu));
    chk("instr_count", 32'(instr_count), 32'(m_ic));
    chk("cycle_count", 32'(cycle_count), 32'(m_cc));
    chk("ir_err", 32'(ir_err), 32'(m_err));
  endtask

  initial begin
    m_pc = 0; m_ir = 0; m_mdr = 0; m_alu = 0;
    m_ic = 0; m_cc = 0; m_err = 0;

    // reset, with a read strobe that must be masked
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
    #1;
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    tick();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_icnt", 32'(instr_count), 32'h0);
    chk("rst_ccnt", 32'(cycle_count), 32'h0);

    // fetch
    drive(0, 1, 0, 1, 0, 1, 0, 1, 'h1234);
    #1;
    chk("fetch_addr", 32'(bus.mem_addr), 32'h0);
    tick();
    chk("fetch_opcode", 32'(opcode), 32'h1);
    chk("fetch_rd", 32'(rd), 32'h2);
    chk("fetch_rs", 32'(rs), 32'h3);
    chk("fetch_rt", 32'(rt), 32'h4);
    chk("fetch_pc", 32'(pc), 32'h1);
    chk("fetch_icnt", 32'(instr_count), 32'h1);

    // branch backwards, then branch with wrap
    drive(0, 1, 0, 1, 0, 1, 0, 'h05, 'h00FE);
    tick();
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("branch_back", 32'(pc), 32'h03);
    drive(0, 1, 0, 1, 0, 1, 0, 'hFF, 'h0002);
    tick();
    chk("pre_wrap_pc", 32'(pc), 32'hFF);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("branch_wrap", 32'(pc), 32'h01);

    // jump, then hold
    drive(0, 0, 0, 1, 0, 1, 0, 0, 'hF0A7);
    tick();
    drive(0, 1, 2, 0, 0, 0, 0, 0, 0);
    tick();
    chk("jump_pc", 32'(pc), 32'hA7);
    drive(0, 1, 3, 0, 0, 0, 0, 'h33, 0);
    tick();
    chk("hold_pc", 32'(pc), 32'hA7);
    drive(0, 0, 0, 0, 0, 0, 0, 'h55, 0);
    tick();
    chk("nowrite_pc", 32'(pc), 32'hA7);

    // data load with read/write conflict
    drive(0, 0, 0, 0, 0, 0, 0, 'h0040, 0);
    tick();
    drive(0, 0, 0, 0, 1, 1, 1, 0, 'hBEEF);
    #1;
    chk("load_addr", 32'(bus.mem_addr), 32'h40);
    chk("rw_mem_write", 32'(bus.mem_write), 32'h0);
    chk("rw_mem_read", 32'(bus.mem_read), 32'h1);
    tick();
    chk("load_mdr", 32'(mdr), 32'hBEEF);

    // IRWrite without MemRead
    drive(0, 0, 0, 1, 0, 0, 0, 0, 'h1111);
    tick();
    chk("irerr_ir", 32'({opcode, rd, rs, rt}), 32'hF0A7);
    chk("irerr_set", 32'(ir_err), 32'h1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("irerr_sticky", 32'(ir_err), 32'h1);

    // reset mid-fetch
    drive(1, 1, 0, 1, 0, 1, 0, 'h22, 'h5678);
    tick();
    chk("reboot_pc", 32'(pc), 32'h0);
    chk("reboot_ir", 32'({opcode, rd, rs, rt}), 32'h0);
    chk("reboot_err", 32'(ir_err), 32'h0);
    chk("reboot_mdr", 32'(mdr), 32'h0);
    chk("reboot_icnt", 32'(instr_count), 32'h0);
    check_state();

    // random strobes against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) == 0,
            1'($urandom), int'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, 1'($urandom),
            $urandom_range(0, 4) != 0, 1'($urandom),
            int'($urandom_range(0, 'hFFFF)),
            int'($urandom_range(0, 'hFFFF)));
      #1;
      check_comb();
      tick();
      check_state();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
